// File: rtl/aux_out_interface.sv
// rtl/aux_out_interface.sv - auxiliary output pins and enables driven by register-side commands
// Optional timed PULSE opcode, FSM and counter are compiled in with AUX_OUT_PULSE_EN.
module aux_out_interface #(
    parameter int                 WIDTH     = 32,
    parameter int                 PULSE_W   = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_data,
    input  logic [PULSE_W-1:0] cmd_len,
    output logic [WIDTH-1:0]   aux_out,
    output logic [WIDTH-1:0]   aux_oe,
    output logic               busy,
    output logic               cmd_err
);

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_SET   = 3'd1;
    localparam logic [2:0] OP_CLR   = 3'd2;
    localparam logic [2:0] OP_TGL   = 3'd3;
    localparam logic [2:0] OP_OE    = 3'd4;

    logic [WIDTH-1:0] aux_q, aux_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic             err_q, err_d;
    logic             accept;

`ifdef AUX_OUT_PULSE_EN
    localparam logic [2:0] OP_PULSE = 3'd5;

    typedef enum logic {S_IDLE, S_PULSE} state_t;

    state_t             state_q, state_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   mask_q, mask_d;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_PULSE);
`else
    logic unused_len;

    assign unused_len = ^cmd_len;
    assign cmd_ready  = 1'b1;
    assign busy       = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        aux_d = aux_q;
        oe_d  = oe_q;
        err_d = 1'b0;
`ifdef AUX_OUT_PULSE_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        // Restore by XOR so bits outside the mask are never touched.
        if (state_q == S_PULSE) begin
            if (cnt_q == '0) begin
                aux_d   = aux_q ^ mask_q;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - PULSE_W'(1);
            end
        end
`endif
        if (accept) begin
            case (cmd_op)
                OP_WRITE: aux_d = cmd_data;
                OP_SET:   aux_d = aux_q | cmd_data;
                OP_CLR:   aux_d = aux_q & ~cmd_data;
                OP_TGL:   aux_d = aux_q ^ cmd_data;
                OP_OE:    oe_d  = cmd_data;
`ifdef AUX_OUT_PULSE_EN
                OP_PULSE: begin
                    // Counter holds remaining cycles minus one; len=0 is a silent no-op.
                    if (cmd_len != '0) begin
                        aux_d   = aux_q ^ cmd_data;
                        mask_d  = cmd_data;
                        cnt_d   = cmd_len - PULSE_W'(1);
                        state_d = S_PULSE;
                    end
                end
`endif
                default:  err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            aux_q <= RESET_VAL;
            oe_q  <= '0;
            err_q <= 1'b0;
        end else begin
            aux_q <= aux_d;
            oe_q  <= oe_d;
            err_q <= err_d;
        end
    end

`ifdef AUX_OUT_PULSE_EN
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end
`endif

    assign aux_out = aux_q;
    assign aux_oe  = oe_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_aux_out_interface.sv
// tb/tb_aux_out_interface.sv - self-checking bench for aux_out_interface
module tb_aux_out_interface;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_data = 32'h0;
    logic [15:0] cmd_len = 16'h0;
    logic [31:0] aux_out;
    logic [31:0] aux_oe;
    logic        busy;
    logic        cmd_err;

    int total = 0;
    int bad   = 0;

    aux_out_interface #(.WIDTH(32), .PULSE_W(16), .RESET_VAL(32'h0)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_len  (cmd_len),
        .aux_out  (aux_out),
        .aux_oe   (aux_oe),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [15:0] len;
        logic [31:0] exp_aux;
        logic [31:0] exp_oe;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One command presented for one cycle; outputs sampled 1 time unit after the edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] data, input logic [15:0] len);
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    vec_t        vecs[$];
    logic [31:0] m_aux;
    logic [31:0] m_oe;
    logic        m_err;
    logic        pulse_en;

    initial begin
`ifdef AUX_OUT_PULSE_EN
        pulse_en = 1'b1;
`else
        pulse_en = 1'b0;
`endif
        // Reset asserted from time zero, then mid-cycle after some state exists.
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        issue(3'd0, 32'h1234_5678, 16'd0);
        issue(3'd4, 32'hFFFF_FFFF, 16'd0);
        cmd_valid = 1'b0;
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        #1;
        check("rst_aux", aux_out, 32'h0);
        check("rst_oe", aux_oe, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_err", cmd_err, 1'b0);
        @(negedge sys_clk);
        sys_rst = 1'b1;

        // Directed table from the datasheet scenarios.
        vecs.push_back('{3'd0, 32'hA5A5_A5A5, 16'd0, 32'hA5A5_A5A5, 32'h0, 1'b0});
        vecs.push_back('{3'd1, 32'h0000_00FF, 16'd0, 32'hA5A5_A5FF, 32'h0, 1'b0});
        vecs.push_back('{3'd2, 32'hFF00_0000, 16'd0, 32'h00A5_A5FF, 32'h0, 1'b0});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 16'd0, 32'hFF5A_5A00, 32'h0, 1'b0});
        vecs.push_back('{3'd4, 32'h0000_FFFF, 16'd0, 32'hFF5A_5A00, 32'h0000_FFFF, 1'b0});
        vecs.push_back('{3'd6, 32'hDEAD_BEEF, 16'd3, 32'hFF5A_5A00, 32'h0000_FFFF, 1'b1});
        vecs.push_back('{3'd7, 32'h0F0F_0F0F, 16'd0, 32'hFF5A_5A00, 32'h0000_FFFF, 1'b1});
        vecs.push_back('{3'd5, 32'hFFFF_FFFF, 16'd0, 32'hFF5A_5A00, 32'h0000_FFFF, !pulse_en});
        vecs.push_back('{3'd0, 32'h0000_0000, 16'd0, 32'h0000_0000, 32'h0000_FFFF, 1'b0});
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].data, vecs[i].len);
            check($sformatf("vec%0d_aux", i), aux_out, vecs[i].exp_aux);
            check($sformatf("vec%0d_oe", i), aux_oe, vecs[i].exp_oe);
            check($sformatf("vec%0d_err", i), cmd_err, vecs[i].exp_err);
            check($sformatf("vec%0d_ready", i), cmd_ready, 1'b1);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
        end
        idle_cycle();
        check("err_one_cycle", cmd_err, 1'b0);

`ifndef AUX_OUT_PULSE_EN
        issue(3'd5, 32'h0000_0001, 16'd5);
        check("nopulse_err", cmd_err, 1'b1);
        check("nopulse_busy", busy, 1'b0);
        check("nopulse_aux", aux_out, 32'h0);
        idle_cycle();
        check("nopulse_busy2", busy, 1'b0);
`endif

        // Random back-to-back commands against a reference model (no running pulses).
        m_aux = aux_out;
        m_oe  = aux_oe;
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  op;
            logic [31:0] d;
            logic [15:0] l;
            op = 3'($urandom_range(0, 7));
            d  = $urandom;
            l  = (op == 3'd5 && pulse_en) ? 16'd0 : 16'($urandom);
            m_err = 1'b0;
            case (op)
                3'd0: m_aux = d;
                3'd1: m_aux = m_aux | d;
                3'd2: m_aux = m_aux & ~d;
                3'd3: m_aux = m_aux ^ d;
                3'd4: m_oe = d;
                3'd5: m_err = !pulse_en;
                default: m_err = 1'b1;
            endcase
            issue(op, d, l);
            check($sformatf("rnd%0d_aux", n), aux_out, m_aux);
            check($sformatf("rnd%0d_oe", n), aux_oe, m_oe);
            check($sformatf("rnd%0d_err", n), cmd_err, m_err);
            check($sformatf("rnd%0d_ready", n), cmd_ready, 1'b1);
        end

`ifdef AUX_OUT_PULSE_EN
        begin
            int hi_cnt;
            int busy_cnt;
            int guard;
            // len 5 pulse on bit 0 with a WRITE queued behind it.
            issue(3'd0, 32'h0, 16'd0);
            issue(3'd5, 32'h0000_0001, 16'd5);
            @(negedge sys_clk);
            cmd_op   = 3'd0;
            cmd_data = 32'h0000_CAFE;
            hi_cnt   = (aux_out == 32'h1) ? 1 : 0;
            busy_cnt = busy ? 1 : 0;
            guard    = 0;
            while (aux_out != 32'h0000_CAFE && guard < 30) begin
                @(posedge sys_clk);
                #1;
                if (aux_out == 32'h1) hi_cnt++;
                if (busy) busy_cnt++;
                if (busy) check("pulse_not_ready", cmd_ready, 1'b0);
                guard++;
            end
            check("pulse_hi_cycles", hi_cnt, 5);
            check("pulse_busy_cycles", busy_cnt, 5);
            check("pulse_write_after", aux_out, 32'h0000_CAFE);
            check("pulse_ready_after", cmd_ready, 1'b1);
            idle_cycle();

            // Maximum length pulse with a mask outside which bits must stay put.
            issue(3'd5, 32'h8000_0000, 16'hFFFF);
            cmd_valid = 1'b0;
            busy_cnt  = 0;
            guard     = 0;
            while (busy && guard < 70000) begin
                if (aux_out != 32'h8000_CAFE) hi_cnt = -1;
                busy_cnt++;
                @(posedge sys_clk);
                #1;
                guard++;
            end
            check("maxpulse_cycles", busy_cnt, 65535);
            check("maxpulse_hold", hi_cnt, 5);
            check("maxpulse_restore", aux_out, 32'h0000_CAFE);

            // Zero-mask pulse: busy for full length, pins quiet.
            issue(3'd5, 32'h0, 16'd3);
            cmd_valid = 1'b0;
            check("zmask_busy", busy, 1'b1);
            repeat (3) begin
                @(posedge sys_clk);
                #1;
            end
            check("zmask_done", busy, 1'b0);
            check("zmask_aux", aux_out, 32'h0000_CAFE);

            // Reset at cycle 3 of a length-10 pulse.
            issue(3'd5, 32'h0000_00F0, 16'd10);
            cmd_valid = 1'b0;
            check("rstp_start", aux_out, 32'h0000_CA0E);
            repeat (2) @(posedge sys_clk);
            #3;
            sys_rst = 1'b0;
            #1;
            check("rstp_aux", aux_out, 32'h0);
            check("rstp_busy", busy, 1'b0);
            check("rstp_ready", cmd_ready, 1'b1);
            @(negedge sys_clk);
            sys_rst = 1'b1;
            hi_cnt = 0;
            repeat (15) begin
                @(posedge sys_clk);
                #1;
                if (aux_out != 32'h0 || busy) hi_cnt++;
            end
            check("rstp_quiet", hi_cnt, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aux_out_interface.md
# aux_out_interface

Output-direction counterpart of the auxiliary input path. It drives the 32-bit auxiliary output pins and their per-bit output enables from register-side commands. Supported commands are write, set, clear, toggle, output-enable update and a timed pulse. All pin-facing outputs are registered in the `sys_clk` domain. The block sits between the APB register file and the pad ring.

## Interface
- `WIDTH`, 32: number of auxiliary output bits.
- `PULSE_W`, 16: width of the pulse length field and of the pulse counter.
- `RESET_VAL`, 32'h0000_0000: value of `aux_out` after reset.

- `sys_clk`  in  1  system clock; the only clock in the block.
- `sys_rst`  in  1  reset; asynchronous, active-low.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  the block can accept a command.
- `cmd_op`  in  3  opcode.
- `cmd_data`  in  WIDTH  value or bit mask, depending on the opcode.
- `cmd_len`  in  PULSE_W  pulse length in cycles; used by PULSE only.
- `aux_out`  out  WIDTH  registered output pin values.
- `aux_oe`  out  WIDTH  registered per-bit output enables; 1 means the bit is driven.
- `busy`  out  1  a pulse is in progress.
- `cmd_err`  out  1  one-cycle pulse when a reserved opcode is accepted.

## Operation
- **Handshake**
  - A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - `cmd_op`, `cmd_data` and `cmd_len` are sampled only at that edge.
  - `cmd_valid` may stay high across commands; one command is accepted per accepting edge.
- **Opcodes**
  - 0 WRITE: `aux_out` = data.
  - 1 SET: `aux_out` |= data.
  - 2 CLR: `aux_out` &= ~data.
  - 3 TGL: `aux_out` ^= data.
  - 4 OE: `aux_oe` = data.
  - 5 PULSE: timed inversion of the masked bits; see below.
  - 6 and 7 are reserved: the command is accepted, no state changes, and `cmd_err` is 1 for the following cycle.
- **FSM states:** IDLE and PULSE.
  - IDLE: `cmd_ready`=1, `busy`=0.
  - IDLE → PULSE: on acceptance of PULSE with `cmd_len`≠0. At that edge `aux_out` ^= mask, the mask is latched, and the counter is loaded with `cmd_len`−1.
  - PULSE with counter≠0: counter decrements each cycle.
  - PULSE with counter=0: at that edge `aux_out` ^= latched mask and the FSM returns to IDLE.
  - PULSE with `cmd_len`=0: accepted as a no-op; the FSM stays in IDLE.
  - PULSE with mask=0: runs the full duration with no visible pin change.
- **PULSE state outputs:** `cmd_ready`=0, `busy`=1. Further commands are held off by the handshake.
- **Pulse width arithmetic:** the masked bits are inverted for exactly `cmd_len` cycles. The maximum is 2^PULSE_W−1 cycles. The counter never wraps.
- **Restore is XOR-based:** bits outside the mask are unaffected. No other opcode can modify them during a pulse, because no command is accepted.
- **`aux_oe` independence:** `aux_oe` never changes `aux_out`. Values are held internally even when the enable bit is 0.

## Timing
- **Reset values:** `aux_out`=RESET_VAL, `aux_oe`=0, `busy`=0, `cmd_err`=0, FSM=IDLE, counter=0, latched mask=0.
- **`cmd_ready` in reset:** 1 as soon as reset deasserts.
- **Reset mid-pulse:** asynchronous return to the reset values. No restore edge is generated.
- **Latency:** every register update is visible on the outputs 1 cycle after the accepting edge. `cmd_err` is also high 1 cycle after its accepting edge, for 1 cycle.
- **Back-to-back commands:** non-PULSE commands are accepted every cycle.
- **After PULSE:** `cmd_ready` returns to 1 in the cycle after the restore edge. A PULSE of length N therefore occupies N cycles of not-ready.
- **Combinational paths:** none from `cmd_*` to `aux_out` or `aux_oe`. `cmd_ready` and `busy` are decoded from the FSM state only.

## Configuration
- **`AUX_OUT_PULSE_EN` defined:**
  - The PULSE opcode, the FSM, the counter and the mask register are compiled in, as described above.
- **`AUX_OUT_PULSE_EN` undefined:**
  - Opcode 5 is treated as reserved and raises `cmd_err`.
  - `cmd_ready` is tied to 1 and `busy` is tied to 0.
  - `cmd_len` is ignored, and no counter is instantiated.

## Test plan
- **Reset:** assert `sys_rst`=0 mid-cycle → `aux_out`=0, `aux_oe`=0, `busy`=0, `cmd_ready`=1 immediately. Release reset, then WRITE 32'hA5A5A5A5 → `aux_out`=A5A5A5A5 one cycle later.
- **Bit ops:** from A5A5A5A5, issue SET 32'h0000_00FF, CLR 32'hFF00_0000 and TGL 32'hFFFF_FFFF back-to-back → `aux_out` = A5A5A5FF, then 00A5A5FF, then FF5A5A00. `cmd_ready` stays 1 throughout.
- **Output enable:** OE 32'h0000_FFFF → `aux_oe`=0000FFFF and `aux_out` unchanged.
- **Pulse:** from `aux_out`=0, PULSE mask 32'h1 with len 5 → bit0=1 for exactly 5 cycles, `busy`=1 for 5 cycles, then bit0=0. A WRITE held valid during the pulse is accepted only afterwards.
- **Pulse edge cases:**
  - len=0 → no change and no busy.
  - len=16'hFFFF → inversion lasts 65535 cycles.
  - Reset at cycle 3 of a len-10 pulse → outputs return to reset values with no further edges.
- **Reserved and compile-out:**
  - Opcode 6 → `cmd_err` high for 1 cycle and `aux_out` unchanged.
  - With `AUX_OUT_PULSE_EN` undefined, opcode 5 → `cmd_err`=1 and `busy` stays 0.
